// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared pipeline-control types and constants for the stall/flush sequencer
// and the ID/EX register that consumes its NOP encoding.
package riscv_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } stall_state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic pipe_hold;
    } pipe_ctrl_t;

    // Field order: pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold
    localparam pipe_ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam pipe_ctrl_t CTRL_HOLD   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam pipe_ctrl_t CTRL_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam pipe_ctrl_t CTRL_BUBBLE = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam pipe_ctrl_t CTRL_RESET  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    function automatic logic load_use_hazard(
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       uses_rs1,
        input logic       uses_rs2,
        input logic [4:0] rd,
        input logic       rd_is_load
    );
        return rd_is_load && (rd != REG_X0) &&
               ((uses_rs1 && (rd == rs1)) || (uses_rs2 && (rd == rs2)));
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + W'(1);
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: arbitrates memory wait,
// taken-branch flush and load-use bubble into pipeline-register controls.
module pipeline_stall_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int TO_W        = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_AddrA,
    input  logic [4:0]       id_AddrB,
    input  logic             id_UsesA,
    input  logic             id_UsesB,
    input  logic [4:0]       ex_rd,
    input  logic             ex_MemRead,
    input  logic             ex_BranchTaken,
    input  logic             mem_Req,
    input  logic             mem_Ack,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic             Pipe_Hold,
    output logic             mem_Timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

    stall_state_e    state, state_next;
    logic [TO_W-1:0] to_cnt, to_cnt_next;
    logic            timeout_set;
    logic            mem_busy;
    logic            load_use;
    pipe_ctrl_t      ctrl;

    assign mem_busy = mem_Req && !mem_Ack;
    assign load_use = load_use_hazard(id_AddrA, id_AddrB, id_UsesA, id_UsesB,
                                      ex_rd, ex_MemRead);

    always_comb begin
        state_next  = state;
        to_cnt_next = to_cnt;
        timeout_set = 1'b0;

        // Branch/load-use resolution as if memory were idle; memory wait overrides below.
        if (ex_BranchTaken)
            ctrl = CTRL_FLUSH;
        else if (load_use)
            ctrl = CTRL_BUBBLE;
        else
            ctrl = CTRL_RUN;

        case (state)
            RUN: begin
                if (mem_busy) begin
                    ctrl        = CTRL_HOLD;
                    state_next  = MEM_WAIT;
                    to_cnt_next = TO_W'(1);
                end
            end
            MEM_WAIT: begin
                // Ack and a dropped request both release without error.
                if (!mem_busy) begin
                    state_next = RUN;
                end else if (to_cnt == TO_LIMIT) begin
                    state_next  = RUN;
                    timeout_set = 1'b1;
                end else begin
                    ctrl        = CTRL_HOLD;
                    to_cnt_next = to_cnt + TO_W'(1);
                end
            end
            default: state_next = RUN;
        endcase

        if (rst)
            ctrl = CTRL_RESET;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            to_cnt      <= '0;
            mem_Timeout <= 1'b0;
        end else begin
            state  <= state_next;
            to_cnt <= to_cnt_next;
            if (timeout_set)
                mem_Timeout <= 1'b1;
        end
    end

    assign PCWrite      = ctrl.pc_write;
    assign IF_ID_Write  = ctrl.if_id_write;
    assign IF_ID_Flush  = ctrl.if_id_flush;
    assign ID_EX_Bubble = ctrl.id_ex_bubble;
    assign Pipe_Hold    = ctrl.pipe_hold;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (!ctrl.pc_write && !rst),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ctrl.if_id_flush && !rst),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: directed hazard scenarios followed
// by randomized traffic, each cycle predicted by a behavioural model.
module tb_pipeline_stall_ctrl;

    localparam int CNT_W       = 4;
    localparam int TO_W        = 8;
    localparam int MEM_TIMEOUT = 5;
    localparam int MAXC        = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [4:0]       id_AddrA = '0, id_AddrB = '0, ex_rd = '0;
    logic             id_UsesA = 1'b0, id_UsesB = 1'b0;
    logic             ex_MemRead = 1'b0, ex_BranchTaken = 1'b0;
    logic             mem_Req = 1'b0, mem_Ack = 1'b0;
    logic             PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Hold;
    logic             mem_Timeout;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    pipeline_stall_ctrl #(
        .CNT_W(CNT_W), .TO_W(TO_W), .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .id_AddrA(id_AddrA), .id_AddrB(id_AddrB),
        .id_UsesA(id_UsesA), .id_UsesB(id_UsesB),
        .ex_rd(ex_rd), .ex_MemRead(ex_MemRead), .ex_BranchTaken(ex_BranchTaken),
        .mem_Req(mem_Req), .mem_Ack(mem_Ack),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Bubble(ID_EX_Bubble), .Pipe_Hold(Pipe_Hold),
        .mem_Timeout(mem_Timeout),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]       ctl;   // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Hold}
        logic             tout;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    // Model state: consecutive stalled cycles of the current access, sticky error, counters.
    int   m_wait  = 0;
    logic m_tout  = 1'b0;
    int   m_stall = 0;
    int   m_flush = 0;

    task automatic step(input logic r, input logic [4:0] a, input logic [4:0] b,
                        input logic ua, input logic ub, input logic [4:0] rd,
                        input logic mr, input logic bt, input logic rq, input logic ak);
        exp_t e;
        logic busy, lu;
        @(posedge clk);
        #1;
        rst = r; id_AddrA = a; id_AddrB = b; id_UsesA = ua; id_UsesB = ub;
        ex_rd = rd; ex_MemRead = mr; ex_BranchTaken = bt; mem_Req = rq; mem_Ack = ak;

        e.tout = m_tout;
        e.sc   = m_stall[CNT_W-1:0];
        e.fc   = m_flush[CNT_W-1:0];
        if (r) begin
            e.ctl   = 5'b00110;
            m_wait  = 0;
            m_tout  = 1'b0;
            m_stall = 0;
            m_flush = 0;
        end else begin
            busy = rq && !ak;
            lu   = mr && (rd != 5'd0) && ((ua && rd == a) || (ub && rd == b));
            if (busy && m_wait < MEM_TIMEOUT) begin
                e.ctl  = 5'b00001;
                m_wait = m_wait + 1;
            end else begin
                if (busy) m_tout = 1'b1;
                m_wait = 0;
                if (bt)      e.ctl = 5'b11110;
                else if (lu) e.ctl = 5'b00010;
                else         e.ctl = 5'b11000;
            end
            if (!e.ctl[4] && m_stall < MAXC) m_stall = m_stall + 1;
            if (e.ctl[2]  && m_flush < MAXC) m_flush = m_flush + 1;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
    endtask

    // Monitor: the control outputs are valid every cycle, so every cycle is a transaction.
    initial begin
        exp_t e, act;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                act = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Hold,
                       mem_Timeout, stall_cycles, flush_count};
                tests++;
                if (act !== e) begin
                    fails++;
                    $display("FAIL ctrl cycle %0d: got ctl=%b tout=%b stall=%0d flush=%0d, want ctl=%b tout=%b stall=%0d flush=%0d",
                             cyc, act.ctl, act.tout, act.sc, act.fc, e.ctl, e.tout, e.sc, e.fc);
                end
            end
        end
    end

    initial begin
        do_reset(2);

        // Load x5 in EX, ID reads rs1=x5: one bubble, then the load has moved on
        step(0, 5'd5, 5'd7, 1, 1, 5'd5, 1, 0, 0, 0);
        step(0, 5'd5, 5'd7, 1, 1, 5'd9, 0, 0, 0, 0);
        idle(2);

        // x0 never hazards
        for (int i = 0; i < 3; i++) step(0, 5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0);

        // Branch and load-use coincident: flush wins
        do_reset(1);
        step(0, 5'd3, 5'd0, 1, 0, 5'd3, 1, 1, 0, 0);
        idle(2);

        // Memory wait 4 cycles with branch held, ack on the 5th
        do_reset(1);
        for (int i = 0; i < 4; i++) step(0, 5'd1, 5'd2, 1, 1, 5'd4, 0, 1, 1, 0);
        step(0, 5'd1, 5'd2, 1, 1, 5'd4, 0, 1, 1, 1);
        idle(2);

        // Same-cycle req+ack in RUN: no stall
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1);
        // Request dropped mid-wait: released without error
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
        idle(2);

        // Timeout: request never acked, released after MEM_TIMEOUT stall cycles
        do_reset(1);
        for (int i = 0; i < MEM_TIMEOUT + 1; i++) step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
        idle(4);
        do_reset(1);
        idle(2);

        // Reset in the 2nd MEM_WAIT cycle
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
        step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0);
        idle(2);

        // 20 load-use stalls: stall counter saturates
        do_reset(1);
        for (int i = 0; i < 20; i++) begin
            step(0, 5'd0, 5'd6, 0, 1, 5'd6, 1, 0, 0, 0);
            idle(1);
        end
        // 20 branch flushes: flush counter saturates
        for (int i = 0; i < 20; i++) step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0);

        // Randomized traffic
        do_reset(1);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 299) == 0,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        end
        idle(1);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
